// File: rtl/ov7670_frame_packer_pkg.sv
// rtl/ov7670_frame_packer_pkg.sv - shared types and constants for the OV7670 frame packer
package ov7670_frame_packer_pkg;

    localparam int FIFO_W = 17;
    localparam logic [FIFO_W-1:0] FRAME_START_MARKER = 17'h10000;

    typedef enum logic [2:0] {
        ST_WAIT_VSYNC,
        ST_SKIP,
        ST_MARKER,
        ST_ACTIVE,
        ST_DROP
    } cap_state_t;

    function automatic logic [FIFO_W-1:0] pixel_word(input logic [7:0] hi, input logic [7:0] lo);
        return {1'b0, hi, lo};
    endfunction

endpackage

// File: rtl/ov7670_frame_packer_cam_sync_stage.sv
// rtl/ov7670_frame_packer_cam_sync_stage.sv - camera input registers with vsync/href edge pulses
module cam_sync_stage #(
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_frame_start,
    output logic       o_href_fall
);

    logic       r_vsync;
    logic       r_vsync_d;
    logic       r_href;
    logic       r_href_d;
    logic [7:0] r_data;
    logic       w_vsync_norm;

    assign w_vsync_norm = VSYNC_ACTIVE_HIGH ? i_vsync : ~i_vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= w_vsync_norm;
            r_vsync_d <= r_vsync;
            r_href    <= i_href;
            r_href_d  <= r_href;
            r_data    <= i_data;
        end
    end

    // A frame begins when the normalised vsync leaves its active level
    assign o_frame_start = r_vsync_d & ~r_vsync;
    assign o_href_fall   = r_href_d & ~r_href;
    assign o_vsync       = r_vsync;
    assign o_href        = r_href;
    assign o_data        = r_data;

endmodule

// File: rtl/ov7670_frame_packer.sv
// rtl/ov7670_frame_packer.sv - packs OV7670 byte pairs into RGB565 words for FIFO_cam
module ov7670_frame_packer
    import ov7670_frame_packer_pkg::*;
#(
    parameter int FRAME_WIDTH       = 640,
    parameter int FRAME_HEIGHT      = 480,
    parameter int SKIP_FRAMES       = 2,
    parameter int VSYNC_ACTIVE_HIGH = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    input  logic              fifo_full,
    output logic [FIFO_W-1:0] fifo_data,
    output logic              fifo_wr_en,
    output logic [15:0]       frame_count,
    output logic              overflow,
    output logic              geom_err,
    output logic              busy
);

    localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0] L_SKIP  = SKIP_W'(SKIP_FRAMES);
    localparam logic [15:0] L_WIDTH  = 16'(FRAME_WIDTH);
    localparam logic [15:0] L_HEIGHT = 16'(FRAME_HEIGHT);

    logic       w_vsync;
    logic       w_href;
    logic [7:0] w_data;
    logic       w_frame_start;
    logic       w_href_fall;

    cam_sync_stage #(
        .VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH != 0)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_vsync      (cam_vsync),
        .i_href       (cam_href),
        .i_data       (cam_data),
        .o_vsync      (w_vsync),
        .o_href       (w_href),
        .o_data       (w_data),
        .o_frame_start(w_frame_start),
        .o_href_fall  (w_href_fall)
    );

    cap_state_t        r_state, w_state_nxt;
    logic [SKIP_W-1:0] r_skip, w_skip_nxt;
    logic              r_phase_hi, w_phase_hi_nxt;
    logic [7:0]        r_hi, w_hi_nxt;
    logic [15:0]       r_pix_cnt, w_pix_nxt;
    logic [15:0]       r_line_cnt, w_line_nxt;
    logic              r_pend, w_pend_nxt;
    logic [FIFO_W-1:0] r_pend_word, w_pend_word_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [FIFO_W-1:0] r_data_out, w_data_nxt;
    logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              r_geom, w_geom_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_WAIT_VSYNC;
            r_skip      <= L_SKIP;
            r_phase_hi  <= 1'b1;
            r_hi        <= 8'h00;
            r_pix_cnt   <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
            r_wr_en     <= 1'b0;
            r_data_out  <= '0;
            r_frame_cnt <= 16'd0;
            r_overflow  <= 1'b0;
            r_geom      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_skip      <= w_skip_nxt;
            r_phase_hi  <= w_phase_hi_nxt;
            r_hi        <= w_hi_nxt;
            r_pix_cnt   <= w_pix_nxt;
            r_line_cnt  <= w_line_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_word <= w_pend_word_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_data_out  <= w_data_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_overflow  <= w_overflow_nxt;
            r_geom      <= w_geom_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_skip_nxt      = r_skip;
        w_phase_hi_nxt  = r_phase_hi;
        w_hi_nxt        = r_hi;
        w_pix_nxt       = r_pix_cnt;
        w_line_nxt      = r_line_cnt;
        w_pend_nxt      = 1'b0;
        w_pend_word_nxt = r_pend_word;
        w_wr_en_nxt     = 1'b0;
        w_data_nxt      = r_data_out;
        w_frame_cnt_nxt = r_frame_cnt;
        w_overflow_nxt  = r_overflow;
        w_geom_nxt      = r_geom;

        // Pixel words leave one edge after their low byte is processed
        if (r_pend) begin
            if (fifo_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_wr_en_nxt = 1'b1;
                w_data_nxt  = r_pend_word;
            end
        end

        unique case (r_state)
            ST_WAIT_VSYNC, ST_SKIP: begin
                if (w_frame_start && capture_en) begin
                    if (r_skip != '0) begin
                        w_skip_nxt  = r_skip - SKIP_W'(1);
                        w_state_nxt = ST_SKIP;
                    end else begin
                        w_state_nxt = ST_MARKER;
                    end
                end
            end
            ST_MARKER: begin
                // Hold off a cycle if the last pixel word is still on the bus
                if (!r_wr_en) begin
                    if (fifo_full) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = ST_DROP;
                    end else begin
                        w_wr_en_nxt     = 1'b1;
                        w_data_nxt      = FRAME_START_MARKER;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                        w_pix_nxt       = 16'd0;
                        w_line_nxt      = 16'd0;
                        w_phase_hi_nxt  = 1'b1;
                        w_state_nxt     = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_href_fall) begin
                    if (!r_phase_hi || r_pix_cnt != L_WIDTH) w_geom_nxt = 1'b1;
                    w_pix_nxt      = 16'd0;
                    w_phase_hi_nxt = 1'b1;
                    w_line_nxt     = r_line_cnt + 16'd1;
                end
                if (w_frame_start) begin
                    if (w_line_nxt != L_HEIGHT) w_geom_nxt = 1'b1;
                    if (capture_en) begin
                        w_state_nxt = ST_MARKER;
                    end else begin
                        w_skip_nxt  = L_SKIP;
                        w_state_nxt = ST_WAIT_VSYNC;
                    end
                end else if (w_vsync && w_href) begin
                    w_geom_nxt  = 1'b1;
                    w_state_nxt = ST_DROP;
                end else if (w_href) begin
                    if (r_phase_hi) begin
                        w_hi_nxt       = w_data;
                        w_phase_hi_nxt = 1'b0;
                    end else begin
                        w_phase_hi_nxt  = 1'b1;
                        w_pend_nxt      = 1'b1;
                        w_pend_word_nxt = pixel_word(r_hi, w_data);
                        w_pix_nxt       = r_pix_cnt + 16'd1;
                        if (r_pix_cnt >= L_WIDTH) w_geom_nxt = 1'b1;
                    end
                end
                if (r_pend && fifo_full && w_state_nxt == ST_ACTIVE) w_state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (w_frame_start) begin
                    if (capture_en) begin
                        w_state_nxt = ST_MARKER;
                    end else begin
                        w_skip_nxt  = L_SKIP;
                        w_state_nxt = ST_WAIT_VSYNC;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_VSYNC;
        endcase
    end

    assign fifo_data   = r_data_out;
    assign fifo_wr_en  = r_wr_en;
    assign frame_count = r_frame_cnt;
    assign overflow    = r_overflow;
    assign geom_err    = r_geom;
    assign busy        = (r_state == ST_MARKER) || (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_ov7670_frame_packer.sv
// tb/tb_ov7670_frame_packer.sv - scoreboard bench for ov7670_frame_packer
module tb_ov7670_frame_packer;

    typedef struct {
        logic [16:0] word;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        reset_n2 = 1'b1;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        capture_en = 1'b1;
    logic        fifo_full = 1'b0;

    logic [16:0] fifo_data, fifo_data2;
    logic        fifo_wr_en, fifo_wr_en2;
    logic [15:0] frame_count, frame_count2;
    logic        overflow, overflow2;
    logic        geom_err, geom_err2;
    logic        busy, busy2;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          full_hold = 0;
    logic [7:0]  byte_val = 8'h12;
    bit          sb_sel2 = 1'b0;
    bit          frame_lost = 1'b0;
    bit          prev_wr1 = 1'b0;
    bit          prev_wr2 = 1'b0;
    exp_t        q1[$];
    exp_t        q2[$];

    ov7670_frame_packer #(
        .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .SKIP_FRAMES(0), .VSYNC_ACTIVE_HIGH(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .fifo_full(fifo_full),
        .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .frame_count(frame_count),
        .overflow(overflow), .geom_err(geom_err), .busy(busy)
    );

    ov7670_frame_packer #(
        .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .SKIP_FRAMES(2), .VSYNC_ACTIVE_HIGH(1)
    ) dut_skip (
        .clk(clk), .reset_n(reset_n2), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .fifo_full(fifo_full),
        .fifo_data(fifo_data2), .fifo_wr_en(fifo_wr_en2), .frame_count(frame_count2),
        .overflow(overflow2), .geom_err(geom_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr_en === 1'b1) begin
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_unexpected got %h required no write", fifo_data);
            end else begin
                e = q1.pop_front();
                if (fifo_data !== e.word) begin
                    n_fail++;
                    $display("FAIL sb1_word got %h required %h", fifo_data, e.word);
                end
                if (e.cyc >= 0 && cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL sb1_latency got cycle %0d required %0d", cyc, e.cyc);
                end
            end
            if (prev_wr1) begin
                n_fail++;
                $display("FAIL sb1_back_to_back got wr_en 1,1 required gap");
            end
        end
        prev_wr1 = (fifo_wr_en === 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr_en2 === 1'b1) begin
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL sb2_unexpected got %h required no write", fifo_data2);
            end else begin
                e = q2.pop_front();
                if (fifo_data2 !== e.word) begin
                    n_fail++;
                    $display("FAIL sb2_word got %h required %h", fifo_data2, e.word);
                end
            end
            if (prev_wr2) begin
                n_fail++;
                $display("FAIL sb2_back_to_back got wr_en 1,1 required gap");
            end
        end
        prev_wr2 = (fifo_wr_en2 === 1'b1);
    end

    task automatic put(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
        fifo_full = (full_hold > 0);
        if (full_hold > 0) full_hold--;
        @(negedge clk);
    endtask

    task automatic push(input logic [16:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc  = c;
        if (sb_sel2) q2.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drive_line(input int nbytes, input bit exp, input int full_byte);
        logic [7:0] hi;
        hi = 8'h00;
        for (int j = 0; j < nbytes; j++) begin
            if (j == full_byte) full_hold = 3;
            if (j % 2 == 1) begin
                if (full_byte >= 0 && j + 2 >= full_byte) frame_lost = 1'b1;
                if (exp && !frame_lost) push({1'b0, hi, byte_val}, cyc + 3);
            end else begin
                hi = byte_val;
            end
            put(1'b0, 1'b1, byte_val);
            byte_val = byte_val + 8'h22;
        end
        repeat (3) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drive_frame(input bit exp, input int b0, input int b1, input int full_byte,
                               input bit drop_cap);
        frame_lost = 1'b0;
        repeat (3) put(1'b1, 1'b0, 8'h00);
        if (exp) push(17'h10000, -1);
        repeat (3) put(1'b0, 1'b0, 8'h00);
        drive_line(b0, exp, full_byte);
        if (drop_cap) capture_en = 1'b0;
        drive_line(b1, exp, -1);
        repeat (2) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        reset_n2 = 1'b0;
        q1.delete();
        q2.delete();
        byte_val = 8'h12;
        capture_en = 1'b1;
        repeat (3) put(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        repeat (2) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_q1_empty(input string name);
        n_tests++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_words got %0d pending required 0", name, q1.size());
        end
    endtask

    task automatic test_reset();
        #1;
        reset_n  = 1'b0;
        reset_n2 = 1'b0;
        repeat (2) put(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_frame_count got %h required 0", frame_count);
        end
        n_tests++;
        if ({fifo_wr_en, fifo_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_fifo got %b/%h required 0/0", fifo_wr_en, fifo_data);
        end
        n_tests++;
        if ({overflow, geom_err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b required 000", {overflow, geom_err, busy});
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_frame(1'b1, 8, 8, -1, 1'b0);
        check_q1_empty("basic");
        n_tests++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_frame_count got %0d required 1", frame_count);
        end
        n_tests++;
        if (geom_err !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags got geom=%b ovf=%b required 0 0", geom_err, overflow);
        end
    endtask

    task automatic test_skip();
        do_reset();
        reset_n  = 1'b0;
        reset_n2 = 1'b1;
        sb_sel2  = 1'b1;
        repeat (2) put(1'b0, 1'b0, 8'h00);
        drive_frame(1'b0, 8, 8, -1, 1'b0);
        drive_frame(1'b0, 8, 8, -1, 1'b0);
        drive_frame(1'b1, 8, 8, -1, 1'b0);
        n_tests++;
        if (q2.size() != 0) begin
            n_fail++;
            $display("FAIL skip_missing_words got %0d pending required 0", q2.size());
        end
        n_tests++;
        if (frame_count2 !== 16'd1) begin
            n_fail++;
            $display("FAIL skip_frame_count got %0d required 1", frame_count2);
        end
        sb_sel2 = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        drive_frame(1'b1, 8, 8, 6, 1'b0);
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag got %b required 1", overflow);
        end
        drive_frame(1'b1, 8, 8, -1, 1'b0);
        check_q1_empty("overflow");
        n_tests++;
        if (frame_count !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_frame_count got %0d required 2", frame_count);
        end
    endtask

    task automatic test_geometry();
        do_reset();
        drive_frame(1'b1, 6, 7, -1, 1'b0);
        check_q1_empty("geometry");
        n_tests++;
        if (geom_err !== 1'b1) begin
            n_fail++;
            $display("FAIL geometry_flag got %b required 1", geom_err);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL geometry_overflow got %b required 0", overflow);
        end
    endtask

    task automatic test_capture_drop();
        do_reset();
        drive_frame(1'b1, 8, 8, -1, 1'b1);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL capdrop_busy_active got %b required 1", busy);
        end
        drive_frame(1'b0, 8, 8, -1, 1'b0);
        check_q1_empty("capdrop");
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL capdrop_busy_idle got %b required 0", busy);
        end
        n_tests++;
        if (frame_count !== 16'd1 || geom_err !== 1'b0) begin
            n_fail++;
            $display("FAIL capdrop_state got count=%0d geom=%b required 1 0", frame_count, geom_err);
        end
        capture_en = 1'b1;
    endtask

    task automatic test_reset_midline();
        logic [7:0] hi;
        hi = 8'h00;
        do_reset();
        repeat (3) put(1'b1, 1'b0, 8'h00);
        push(17'h10000, -1);
        repeat (3) put(1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 7; j++) begin
            if (j % 2 == 1) begin
                if (j + 3 <= 7) push({1'b0, hi, byte_val}, cyc + 3);
            end else begin
                hi = byte_val;
            end
            put(1'b0, 1'b1, byte_val);
            byte_val = byte_val + 8'h22;
        end
        n_tests++;
        if (frame_count !== 16'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_before got count=%0d busy=%b required 1 1", frame_count, busy);
        end
        check_q1_empty("midreset_pre");
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({fifo_wr_en, frame_count, busy, overflow, geom_err} !== 20'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got wr=%b count=%0d busy=%b required all 0",
                     fifo_wr_en, frame_count, busy);
        end
        repeat (2) put(1'b0, 1'b1, 8'h55);
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) put(1'b0, 1'b1, 8'hA0 + 8'(j));
        repeat (3) put(1'b0, 1'b0, 8'h00);
        drive_line(8, 1'b0, -1);
        drive_frame(1'b1, 8, 8, -1, 1'b0);
        check_q1_empty("midreset_post");
        n_tests++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_frame_count got %0d required 1", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_overflow();
        test_geometry();
        test_capture_drop();
        test_reset_midline();
        repeat (4) put(1'b0, 1'b0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
